// File: rtl/spi_flash_emu_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_emu_responder_if
// Purpose  : Bundles the SPI pad signals, the backing-memory read port and
//            the status outputs of the SPI flash responder.
//            slave  = responder side, master = board / memory / monitor side.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_flash_emu_responder_if #(
  parameter int MEM_AW = 16
);
  logic              spi_sck_i;
  logic              spi_csb_i;
  logic              spi_mosi_i;
  logic              spi_miso_o;
  logic              spi_miso_oe_o;
  logic              mem_req_o;
  logic [MEM_AW-1:0] mem_addr_o;
  logic [7:0]        mem_rdata_i;
  logic              busy_o;
  logic              cmd_err_o;
  logic [15:0]       rd_count_o;

  modport slave (
    input  spi_sck_i, spi_csb_i, spi_mosi_i, mem_rdata_i,
    output spi_miso_o, spi_miso_oe_o, mem_req_o, mem_addr_o,
           busy_o, cmd_err_o, rd_count_o
  );

  modport master (
    output spi_sck_i, spi_csb_i, spi_mosi_i, mem_rdata_i,
    input  spi_miso_o, spi_miso_oe_o, mem_req_o, mem_addr_o,
           busy_o, cmd_err_o, rd_count_o
  );
endinterface
`default_nettype wire

// File: rtl/spi_flash_emu_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_emu_responder
// Purpose  : Mode-0 single-lane SPI flash responder serving reads (0x03),
//            JEDEC ID (0x9F) and status (0x05) from an on-chip byte memory.
//            All SPI inputs are oversampled in the clk_i domain.
//            Optional: define SPI_FLASH_EMU_FAST_READ_EN to add fast read
//            (0x0B, 8 dummy clocks); otherwise 0x0B is an unsupported opcode.
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_emu_responder #(
  parameter int          MEM_AW      = 16,
  parameter int          SYNC_STAGES = 2,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4018
) (
  input wire clk_i,
  input wire rst_i,
  spi_flash_emu_responder_if.slave bus
);

  typedef enum logic [2:0] {
    ST_WAIT_CS = 3'd0,
    ST_IDLE    = 3'd1,
    ST_CMD     = 3'd2,
    ST_ADDR    = 3'd3,
    ST_DATA    = 3'd4,
`ifdef SPI_FLASH_EMU_FAST_READ_EN
    ST_IGNORE  = 3'd5,
    ST_DUMMY   = 3'd6
`else
    ST_IGNORE  = 3'd5
`endif
  } state_t;

  typedef enum logic [1:0] {
    SRC_MEM  = 2'd0,
    SRC_ID   = 2'd1,
    SRC_STAT = 2'd2
  } src_t;

  // Cycles the synchronizers need after reset before synced CSB is trusted.
  localparam logic [7:0] WAIT_FLUSH = 8'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] csb_sync_q, csb_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   csb_prev_q, csb_prev_d;

  state_t      state_q, state_d;
  src_t        src_q, src_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  opc_q, opc_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  shift_out_q, shift_out_d;
  logic [7:0]  pref_q, pref_d;
  logic [1:0]  id_idx_q, id_idx_d;
  logic        fall_armed_q, fall_armed_d;
  logic        mem_req_q, mem_req_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic        req_first_q, req_first_d;
  logic        rdata_vld_q, rdata_vld_d;
  logic        vld_first_q, vld_first_d;
  logic [15:0] rd_count_q, rd_count_d;
  logic        cmd_err_q, cmd_err_d;
  logic        busy_q, busy_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
`ifdef SPI_FLASH_EMU_FAST_READ_EN
  logic        fast_q, fast_d;
`endif

  logic        sck_s, csb_s, mosi_s;
  logic        sck_rise, sck_fall, csb_rise, csb_fall;
  logic [7:0]  opcode;
  logic [23:0] addr_inc;
  logic        start_read;

  // Synchronizer shift and edge-detect history.
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], bus.spi_sck_i};
    csb_sync_d  = {csb_sync_q[SYNC_STAGES-2:0], bus.spi_csb_i};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi_i};
    sck_s       = sck_sync_q[SYNC_STAGES-1];
    csb_s       = csb_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    sck_prev_d  = sck_s;
    csb_prev_d  = csb_s;
    sck_rise    = sck_s & ~sck_prev_q;
    sck_fall    = ~sck_s & sck_prev_q;
    csb_rise    = csb_s & ~csb_prev_q;
    csb_fall    = ~csb_s & csb_prev_q;
  end

  // Protocol FSM: command decode, address capture, byte shifting and prefetch.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    bit_cnt_d    = bit_cnt_q;
    opc_d        = opc_q;
    addr_d       = addr_q;
    shift_out_d  = shift_out_q;
    pref_d       = pref_q;
    id_idx_d     = id_idx_q;
    fall_armed_d = fall_armed_q;
    mem_req_d    = 1'b0;
    mem_addr_d   = mem_addr_q;
    req_first_d  = req_first_q;
    rdata_vld_d  = mem_req_q;
    vld_first_d  = req_first_q;
    rd_count_d   = rd_count_q;
    cmd_err_d    = 1'b0;
    wait_cnt_d   = wait_cnt_q;
`ifdef SPI_FLASH_EMU_FAST_READ_EN
    fast_d       = fast_q;
`endif
    start_read   = 1'b0;
    opcode       = {opc_q, mosi_s};
    addr_inc     = addr_q + 24'd1;

    if (csb_rise) begin
      // End of transaction wins over any SCK edge seen in the same cycle;
      // in-flight memory data is discarded.
      state_d      = ST_IDLE;
      rdata_vld_d  = 1'b0;
      fall_armed_d = 1'b0;
    end else begin
      case (state_q)
        ST_WAIT_CS: begin
          if (wait_cnt_q != WAIT_FLUSH) wait_cnt_d = wait_cnt_q + 8'd1;
          else if (csb_s)               state_d    = ST_IDLE;
        end
        ST_IDLE: begin
          if (csb_fall) begin
            state_d   = ST_CMD;
            bit_cnt_d = 5'd0;
          end
        end
        ST_CMD: begin
          if (sck_rise) begin
            opc_d     = opcode[6:0];
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d    = 5'd0;
              fall_armed_d = 1'b0;
              case (opcode)
                8'h03: begin
                  state_d = ST_ADDR;
`ifdef SPI_FLASH_EMU_FAST_READ_EN
                  fast_d  = 1'b0;
`endif
                end
`ifdef SPI_FLASH_EMU_FAST_READ_EN
                8'h0B: begin
                  state_d = ST_ADDR;
                  fast_d  = 1'b1;
                end
`endif
                8'h9F: begin
                  state_d     = ST_DATA;
                  src_d       = SRC_ID;
                  shift_out_d = JEDEC_ID[23:16];
                  id_idx_d    = 2'd1;
                end
                8'h05: begin
                  state_d     = ST_DATA;
                  src_d       = SRC_STAT;
                  shift_out_d = 8'h00;
                end
                default: begin
                  state_d   = ST_IGNORE;
                  cmd_err_d = 1'b1;
                end
              endcase
            end
          end
        end
        ST_ADDR: begin
          if (sck_rise) begin
            addr_d    = {addr_q[22:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d = 5'd0;
`ifdef SPI_FLASH_EMU_FAST_READ_EN
              if (fast_q) state_d    = ST_DUMMY;
              else        start_read = 1'b1;
`else
              start_read = 1'b1;
`endif
            end
          end
        end
`ifdef SPI_FLASH_EMU_FAST_READ_EN
        ST_DUMMY: begin
          if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d  = 5'd0;
              start_read = 1'b1;
            end
          end
        end
`endif
        ST_DATA: begin
          // Rises count bits taken by the master; only falls that follow a
          // rise of this phase move MISO, so the fall closing the last
          // command/address bit leaves the freshly loaded bit 7 in place.
          if (sck_rise) begin
            fall_armed_d = 1'b1;
            bit_cnt_d    = {2'b00, bit_cnt_q[2:0] + 3'd1};
            if (bit_cnt_q[2:0] == 3'd7 && src_q == SRC_MEM)
              rd_count_d = rd_count_q + 16'd1;
          end else if (sck_fall && fall_armed_q) begin
            fall_armed_d = 1'b0;
            if (bit_cnt_q[2:0] == 3'd0) begin
              case (src_q)
                SRC_MEM: shift_out_d = pref_q;
                SRC_ID: begin
                  case (id_idx_q)
                    2'd1: begin
                      shift_out_d = JEDEC_ID[15:8];
                      id_idx_d    = 2'd2;
                    end
                    2'd2: begin
                      shift_out_d = JEDEC_ID[7:0];
                      id_idx_d    = 2'd3;
                    end
                    default: shift_out_d = 8'h00;
                  endcase
                end
                default: shift_out_d = 8'h00;
              endcase
            end else begin
              shift_out_d = {shift_out_q[6:0], 1'b0};
            end
            if (bit_cnt_q[2:0] == 3'd6 && src_q == SRC_MEM) begin
              addr_d      = addr_inc;
              mem_req_d   = 1'b1;
              mem_addr_d  = addr_inc[MEM_AW-1:0];
              req_first_d = 1'b0;
            end
          end
          if (rdata_vld_q) begin
            if (vld_first_q) shift_out_d = bus.mem_rdata_i;
            else             pref_d      = bus.mem_rdata_i;
          end
        end
        default: ;
      endcase

      if (start_read) begin
        state_d      = ST_DATA;
        src_d        = SRC_MEM;
        mem_req_d    = 1'b1;
        mem_addr_d   = addr_d[MEM_AW-1:0];
        req_first_d  = 1'b1;
        shift_out_d  = 8'h00;
        fall_armed_d = 1'b0;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers; reset aborts any transaction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_sync_q   <= '0;
      csb_sync_q   <= '1;
      mosi_sync_q  <= '0;
      sck_prev_q   <= 1'b0;
      csb_prev_q   <= 1'b1;
      state_q      <= ST_WAIT_CS;
      src_q        <= SRC_MEM;
      bit_cnt_q    <= 5'd0;
      opc_q        <= 7'd0;
      addr_q       <= 24'd0;
      shift_out_q  <= 8'd0;
      pref_q       <= 8'd0;
      id_idx_q     <= 2'd0;
      fall_armed_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      req_first_q  <= 1'b0;
      rdata_vld_q  <= 1'b0;
      vld_first_q  <= 1'b0;
      rd_count_q   <= 16'd0;
      cmd_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      wait_cnt_q   <= 8'd0;
`ifdef SPI_FLASH_EMU_FAST_READ_EN
      fast_q       <= 1'b0;
`endif
    end else begin
      sck_sync_q   <= sck_sync_d;
      csb_sync_q   <= csb_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      sck_prev_q   <= sck_prev_d;
      csb_prev_q   <= csb_prev_d;
      state_q      <= state_d;
      src_q        <= src_d;
      bit_cnt_q    <= bit_cnt_d;
      opc_q        <= opc_d;
      addr_q       <= addr_d;
      shift_out_q  <= shift_out_d;
      pref_q       <= pref_d;
      id_idx_q     <= id_idx_d;
      fall_armed_q <= fall_armed_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      req_first_q  <= req_first_d;
      rdata_vld_q  <= rdata_vld_d;
      vld_first_q  <= vld_first_d;
      rd_count_q   <= rd_count_d;
      cmd_err_q    <= cmd_err_d;
      busy_q       <= busy_d;
      wait_cnt_q   <= wait_cnt_d;
`ifdef SPI_FLASH_EMU_FAST_READ_EN
      fast_q       <= fast_d;
`endif
    end
  end

  assign bus.spi_miso_oe_o = (state_q == ST_DATA);
  assign bus.spi_miso_o    = (state_q == ST_DATA) & shift_out_q[7];
  assign bus.mem_req_o     = mem_req_q;
  assign bus.mem_addr_o    = mem_addr_q;
  assign bus.busy_o        = busy_q;
  assign bus.cmd_err_o     = cmd_err_q;
  assign bus.rd_count_o    = rd_count_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_emu_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_flash_emu_responder
// Purpose  : Directed self-checking bench for spi_flash_emu_responder:
//            JEDEC ID, reads, address aliasing, bad opcode, aborts, reset
//            mid-transaction and fast read (0x0B).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_flash_emu_responder;

  localparam int MEM_AW      = 16;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   req_cnt = 0;
  int   err_cnt = 0;
  int   oe_cyc  = 0;
  logic [7:0] mem [0:65535];

  spi_flash_emu_responder_if #(.MEM_AW(MEM_AW)) bus ();

  spi_flash_emu_responder #(
    .MEM_AW      (MEM_AW),
    .SYNC_STAGES (SYNC_STAGES),
    .JEDEC_ID    (24'hEF4018)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous backing memory: data valid one clock after the request.
  always @(posedge clk) begin
    if (bus.mem_req_o) bus.mem_rdata_i <= mem[bus.mem_addr_o];
  end

  // Running event counters; checks compare differences across a window.
  always @(negedge clk) begin
    if (bus.mem_req_o)     req_cnt <= req_cnt + 1;
    if (bus.cmd_err_o)     err_cnt <= err_cnt + 1;
    if (bus.spi_miso_oe_o) oe_cyc  <= oe_cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Mode 0 master: MISO sampled just before each rising edge.
  task automatic xfer(input int nbits, input logic [7:0] tx,
                      output logic [7:0] rx, output logic oe_any);
    rx     = 8'h00;
    oe_any = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      bus.spi_mosi_i = tx[7-i];
      repeat (HALF) @(negedge clk);
      rx     = {rx[6:0], bus.spi_miso_o};
      oe_any = oe_any | bus.spi_miso_oe_o;
      bus.spi_sck_i = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.spi_sck_i = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] tx);
    logic [7:0] rx;
    logic       oe;
    xfer(8, tx, rx, oe);
  endtask

  task automatic rd_byte(input string tag, input logic [7:0] exp);
    logic [7:0] rx;
    logic       oe;
    xfer(8, 8'h00, rx, oe);
    check(tag, {24'd0, rx}, {24'd0, exp});
  endtask

  task automatic cs_low();
    bus.spi_csb_i = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge clk);
    bus.spi_csb_i = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  initial begin
    logic [7:0] rx;
    logic       oe;
    int         r0, e0, o0;

    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'hA5;
    bus.spi_sck_i  = 1'b0;
    bus.spi_csb_i  = 1'b1;
    bus.spi_mosi_i = 1'b0;

    // Reset values.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_miso",    {31'd0, bus.spi_miso_o},    32'd0);
    check("rst_oe",      {31'd0, bus.spi_miso_oe_o}, 32'd0);
    check("rst_memreq",  {31'd0, bus.mem_req_o},     32'd0);
    check("rst_busy",    {31'd0, bus.busy_o},        32'd0);
    check("rst_cmderr",  {31'd0, bus.cmd_err_o},     32'd0);
    check("rst_rdcount", {16'd0, bus.rd_count_o},    32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_busy", {31'd0, bus.busy_o}, 32'd0);

    // JEDEC ID.
    cs_low();
    xfer(8, 8'h9F, rx, oe);
    check("id_cmd_oe", {31'd0, oe}, 32'd0);
    rd_byte("id_b0", 8'hEF);
    rd_byte("id_b1", 8'h40);
    rd_byte("id_b2", 8'h18);
    rd_byte("id_b3", 8'h00);
    rd_byte("id_b4", 8'h00);
    check("id_oe_data", {31'd0, bus.spi_miso_oe_o}, 32'd1);
    check("id_busy",    {31'd0, bus.busy_o},        32'd1);
    cs_high();
    check("id_rdcount", {16'd0, bus.rd_count_o}, 32'd0);
    check("id_oe_end",  {31'd0, bus.spi_miso_oe_o}, 32'd0);

    // Read 4 bytes from 0x000010.
    r0 = req_cnt;
    cs_low();
    send(8'h03); send(8'h00); send(8'h00); send(8'h10);
    rd_byte("rd_b0", 8'hB5);
    rd_byte("rd_b1", 8'hB4);
    rd_byte("rd_b2", 8'hB7);
    rd_byte("rd_b3", 8'hB6);
    cs_high();
    check("rd_count4", {16'd0, bus.rd_count_o}, 32'd4);
    check("rd_memreq", 32'(req_cnt - r0), 32'd5);

    // Address aliasing above the memory range.
    cs_low();
    send(8'h03); send(8'h00); send(8'hFF); send(8'hFF);
    rd_byte("wrap_ffff", 8'h5A);
    rd_byte("wrap_0000", 8'hA5);
    cs_high();
    cs_low();
    send(8'h03); send(8'h01); send(8'h00); send(8'h00);
    rd_byte("alias_10000", 8'hA5);
    cs_high();
    check("wrap_rdcount", {16'd0, bus.rd_count_o}, 32'd7);

    // Unsupported opcode.
    e0 = err_cnt;
    o0 = oe_cyc;
    cs_low();
    send(8'h5A); send(8'h00); send(8'h00);
    repeat (HALF) @(negedge clk);
    check("bad_busy",  {31'd0, bus.busy_o}, 32'd1);
    check("bad_err",   32'(err_cnt - e0), 32'd1);
    check("bad_oe",    32'(oe_cyc - o0),  32'd0);
    bus.spi_csb_i = 1'b1;
    repeat (SYNC_STAGES + 2) @(negedge clk);
    check("bad_idle",  {31'd0, bus.busy_o}, 32'd0);
    repeat (HALF) @(negedge clk);

    // Abort after 12 address bits, then status read.
    r0 = req_cnt;
    e0 = err_cnt;
    cs_low();
    send(8'h03);
    xfer(8, 8'h00, rx, oe);
    xfer(4, 8'h00, rx, oe);
    repeat (HALF) @(negedge clk);
    bus.spi_csb_i = 1'b1;
    repeat (SYNC_STAGES + 2) @(negedge clk);
    check("abort_busy",   {31'd0, bus.busy_o}, 32'd0);
    check("abort_memreq", 32'(req_cnt - r0), 32'd0);
    check("abort_err",    32'(err_cnt - e0), 32'd0);
    repeat (HALF) @(negedge clk);
    cs_low();
    send(8'h05);
    rd_byte("stat_b0", 8'h00);
    rd_byte("stat_b1", 8'h00);
    check("stat_oe", {31'd0, bus.spi_miso_oe_o}, 32'd1);
    cs_high();
    check("stat_rdcount", {16'd0, bus.rd_count_o}, 32'd7);

    // Reset in the middle of a data byte with CSB held low.
    cs_low();
    send(8'h03); send(8'h00); send(8'h00); send(8'h00);
    xfer(4, 8'h00, rx, oe);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rstmid_oe",      {31'd0, bus.spi_miso_oe_o}, 32'd0);
    check("rstmid_rdcount", {16'd0, bus.rd_count_o},    32'd0);
    rst = 1'b0;
    o0 = oe_cyc;
    send(8'h03); send(8'h00);
    check("rstmid_no_oe", 32'(oe_cyc - o0), 32'd0);
    check("rstmid_busy",  {31'd0, bus.busy_o}, 32'd1);
    cs_high();
    check("rstmid_idle",  {31'd0, bus.busy_o}, 32'd0);

    // Fast read 0x0B with 8 dummy clocks.
    e0 = err_cnt;
    cs_low();
    send(8'h0B); send(8'h00); send(8'h00); send(8'h10);
    send(8'h00);
`ifdef SPI_FLASH_EMU_FAST_READ_EN
    rd_byte("fast_b0", 8'hB5);
    cs_high();
    check("fast_err",     32'(err_cnt - e0), 32'd0);
    check("fast_rdcount", {16'd0, bus.rd_count_o}, 32'd1);
`else
    rd_byte("fast_b0", 8'h00);
    cs_high();
    check("fast_err",     32'(err_cnt - e0), 32'd1);
    check("fast_rdcount", {16'd0, bus.rd_count_o}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
